// File: rtl/serial_exp_sub.sv
// Bit-serial exponent subtractor: |ea - eb| and sign, LSB first, with a serial negate pass on borrow.
// Optional clamp of abs_diff to SAT_MAX is compiled in with SERIAL_EXP_SUB_SAT_EN.
module serial_exp_sub #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned SAT_MAX = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] abs_diff,
    output logic             a_lt_b,
    output logic             sat
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_NEG,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] abs_q, abs_d;
    logic             lt_q, lt_d;
    logic             sat_q, sat_d;

    logic             bit_a, bit_b, bit_out, last_bit, load;
    logic [WIDTH-1:0] fin_res;
    logic             fin_lt;

    // Next-state, serial datapath and result capture
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        abs_d    = abs_q;
        lt_d     = lt_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        bit_a    = opa_q[0];
        bit_b    = opb_q[0];
        bit_out  = 1'b0;
        load     = 1'b0;
        fin_res  = res_q;
        fin_lt   = 1'b0;
        last_bit = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d    = ea;
                    opb_d    = eb;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_SUB;
                end
            end
            S_SUB: begin
                bit_out  = bit_a ^ bit_b ^ borrow_q;
                borrow_d = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
                res_d    = {bit_out, res_q[WIDTH-1:1]};
                opa_d    = opa_q >> 1;
                opb_d    = opb_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    if (borrow_d) begin
                        // borrow register doubles as the +1 carry of the negate pass
                        borrow_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_NEG;
                    end else begin
                        load    = 1'b1;
                        fin_res = res_d;
                        fin_lt  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_NEG: begin
                bit_out  = ~res_q[0] ^ borrow_q;
                borrow_d = ~res_q[0] & borrow_q;
                res_d    = {bit_out, res_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    load    = 1'b1;
                    fin_res = res_d;
                    fin_lt  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            done_d = 1'b1;
            lt_d   = fin_lt;
`ifdef SERIAL_EXP_SUB_SAT_EN
            if (fin_res > WIDTH'(SAT_MAX)) begin
                abs_d = WIDTH'(SAT_MAX);
                sat_d = 1'b1;
            end else begin
                abs_d = fin_res;
                sat_d = 1'b0;
            end
`else
            abs_d = fin_res;
            sat_d = 1'b0;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abs_q    <= '0;
            lt_q     <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abs_q    <= abs_d;
            lt_q     <= lt_d;
            sat_q    <= sat_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign abs_diff = abs_q;
    assign a_lt_b   = lt_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_serial_exp_sub.sv
// Scoreboard bench for serial_exp_sub: driver pushes expected results, a done-triggered monitor checks them.
module tb_serial_exp_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] ea;
    logic [4:0] eb;
    logic       busy;
    logic       done;
    logic [4:0] abs_diff;
    logic       a_lt_b;
    logic       sat;

    typedef struct {
        int abs_v;
        int lt;
        int sat_v;
        int lat;
        int start_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   prev_abs = 0;
    int   prev_lt = 0;
    int   prev_sat = 0;

    serial_exp_sub #(.WIDTH(5), .SAT_MAX(14)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ea       (ea),
        .eb       (eb),
        .busy     (busy),
        .done     (done),
        .abs_diff (abs_diff),
        .a_lt_b   (a_lt_b),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("abs_diff", int'(abs_diff), e.abs_v);
                check("a_lt_b", int'(a_lt_b), e.lt);
                check("sat", int'(sat), e.sat_v);
                check("latency", cyc - e.start_cyc, e.lat);
            end
        end
    end

    // Issue one request; caller is positioned just after a rising edge
    task automatic run_op(input logic [4:0] a, input logic [4:0] b,
                          input int exp_abs, input int exp_lt, input bit spam);
        exp_t e;
        int   n;
        int   busy_n;
        bit   seen;
        e.abs_v     = exp_abs;
        e.lt        = exp_lt;
        e.sat_v     = 0;
`ifdef SERIAL_EXP_SUB_SAT_EN
        if (exp_abs > 14) begin
            e.abs_v = 14;
            e.sat_v = 1;
        end
`endif
        e.lat       = (exp_lt != 0) ? 11 : 6;
        e.start_cyc = cyc;
        ea    = a;
        eb    = b;
        start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (spam) begin
            ea = ~a;
            eb = ~b;
        end else begin
            start = 1'b0;
        end
        n      = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("hold_abs", int'(abs_diff), prev_abs);
                check("hold_lt", int'(a_lt_b), prev_lt);
            end
            if (spam) begin
                start = 1'b1;
                ea    = 5'($urandom);
                eb    = 5'($urandom);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        else check("busy_cycles", busy_n, e.lat);
        @(posedge clk);
        #1;
        start    = 1'b0;
        prev_abs = e.abs_v;
        prev_lt  = e.lt;
        prev_sat = e.sat_v;
        @(posedge clk);
        #1;
        check("idle_after_op", int'(busy), 0);
    endtask

    initial begin
        bit late_done;
        rst_n = 1'b0;
        start = 1'b0;
        ea    = '0;
        eb    = '0;
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_abs", int'(abs_diff), 0);
        check("rst_lt", int'(a_lt_b), 0);
        check("rst_sat", int'(sat), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(5'd20, 5'd15, 5, 0, 1'b0);
        run_op(5'd3, 5'd17, 14, 1, 1'b0);
        run_op(5'd9, 5'd9, 0, 0, 1'b0);
        run_op(5'd0, 5'd31, 31, 1, 1'b0);
        run_op(5'd31, 5'd0, 31, 0, 1'b0);
        run_op(5'd3, 5'd17, 14, 1, 1'b1);

        // Abort 20/15 with reset at SUB bit 2
        start = 1'b1;
        ea    = 5'd20;
        eb    = 5'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_abs", int'(abs_diff), 0);
        check("abort_lt", int'(a_lt_b), 0);
        check("abort_sat", int'(sat), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        prev_abs = 0;
        prev_lt  = 0;
        prev_sat = 0;
        late_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) late_done = 1'b1;
        end
        check("abort_no_done", int'(late_done), 0);
        @(posedge clk);
        #1;

        run_op(5'd20, 5'd15, 5, 0, 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_exp_sub.md
Name: serial_exp_sub

Overview:
- Bit-serial exponent subtractor for the half-precision add/sub datapath.
- Computes |ea − eb| and the sign of (ea − eb) one bit per clock, LSB first, with a registered borrow.
- When the raw result borrows, a second serial pass negates it (two's complement).
- Replaces the parallel ripple exponent subtractor where area matters more than latency. Feeds the mantissa alignment shifter: the shift amount is abs_diff, and a_lt_b selects which mantissa is shifted.

Parameters:
- WIDTH, 5, exponent width in bits. FP16 = 5.
- SAT_MAX, 14, clamp value for abs_diff. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only in IDLE.
- ea  input  WIDTH  exponent A, unsigned. Latched when start is accepted.
- eb  input  WIDTH  exponent B, unsigned. Latched when start is accepted.
- busy  output  1  high in SUB, NEG and DONE.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- abs_diff  output  WIDTH  |ea − eb|.
- a_lt_b  output  1  1 when ea < eb.
- sat  output  1  abs_diff was clamped. Tied to 0 without the optional feature.

Behaviour:
- Reset (async, rst_n = 0): state IDLE; busy, done, abs_diff, a_lt_b, sat all 0; internal operand/result shift registers, borrow and bit counter all 0.
- States: IDLE, SUB, NEG, DONE. Bit counter width is $clog2(WIDTH+1).
- IDLE:
  - start = 1 → latch ea/eb into shift registers, clear borrow and counter, go to SUB.
  - start = 0 → stay in IDLE.
- SUB, one bit per cycle:
  - a = opA[0], b = opB[0], bw = borrow.
  - d = a ^ b ^ bw; borrow ← (~a & b) | (~(a ^ b) & bw).
  - d shifts into the result MSB (result shifts right); operands shift right; counter increments.
  - After WIDTH cycles: final borrow = 1 → go to NEG, with carry preset to 1 and counter cleared. Otherwise go to DONE.
- NEG, WIDTH cycles, serial invert-plus-one:
  - r = result[0]; bit = ~r ^ c; c ← ~r & c.
  - bit shifts into the result MSB; then go to DONE.
- DONE, one cycle:
  - done = 1.
  - abs_diff ← result; a_lt_b ← (pass went through NEG); sat per the optional feature.
  - Go to IDLE.
- Output holding: abs_diff, a_lt_b and sat are registered, update only on the transition into DONE, and hold until the next result. They never show partial values.
- Latency, counted from the cycle start is sampled to the cycle done is high:
  - WIDTH + 1 cycles when ea ≥ eb.
  - 2·WIDTH + 1 cycles when ea < eb.
- start while busy (SUB/NEG/DONE): ignored, with no effect on the operation in flight. start high in the DONE cycle is also ignored; the next request is accepted in IDLE.
- ea = eb: result 0, no borrow, no NEG pass, a_lt_b = 0.
- Extremes: the magnitude always fits in WIDTH bits; 0 − (2^WIDTH − 1) gives 2^WIDTH − 1 with a_lt_b = 1.
- Reset mid-operation: immediate return to the reset state. No done pulse; previous results are cleared to 0.
- Inputs ea/eb after acceptance: changes have no effect.

Optional Feature:
- Macro SERIAL_EXP_SUB_SAT_EN.
- Defined: on entry to DONE, if result > SAT_MAX then abs_diff ← SAT_MAX and sat ← 1; otherwise abs_diff ← result and sat ← 0. The clamp is an unsigned compare. Latency is unchanged.
- Undefined: no comparator is built, abs_diff is always the exact magnitude, and sat is constant 0.

Test Plan:
- Reset then start with ea = 20, eb = 15 → done exactly 6 cycles after the start cycle; abs_diff = 5, a_lt_b = 0, busy high for 6 cycles.
- ea = 3, eb = 17 → done 11 cycles after start; abs_diff = 14, a_lt_b = 1. Then ea = 9, eb = 9 → abs_diff = 0, a_lt_b = 0, done after 6 cycles.
- ea = 0, eb = 31 → abs_diff = 31, a_lt_b = 1. ea = 31, eb = 0 → abs_diff = 31, a_lt_b = 0 (macro undefined, sat = 0). With SERIAL_EXP_SUB_SAT_EN: abs_diff = 14, sat = 1 in both cases. For 20/15: abs_diff = 5, sat = 0.
- start pulsed every cycle during a 3/17 operation, with ea/eb toggled → one done only, result still 14/1; outputs hold the previous result until that done.
- rst_n driven low for 1 cycle at SUB bit 2 → outputs 0 immediately, no done. A new start of 20/15 afterwards completes normally: abs_diff = 5 at 6 cycles.
